full_neuron_pif_multi: RTL and testbench
========================================

# full_neuron_pif_multi

Multi-channel, parametrised successor to the single-lane PIF neuron controller. It accumulates NUM_CH parallel signed weight streams in blocks of BLOCK_LEN weights, saturating each block's partial sum into that channel's membrane potential, then fires every channel against a shared threshold with reset-by-subtraction. It sits between the weight memory and the spike buffer, one instance per neuron group per layer.

## Interface
- INTEGER_WIDTH, 8: integer bits of membrane potential
- FRACTION_WIDTH, 8: fraction bits; also the weight width (signed, pure fraction)
- DATA_WIDTH, INTEGER_WIDTH+FRACTION_WIDTH: membrane width, signed Q(I.F)
- SIZE_CODE, 5: BLOCK_LEN = 2**SIZE_CODE weights per block
- NUM_CH, 4: parallel neuron lanes
- LEAK_SHIFT, 4: leak divisor exponent (used only with leak compiled in)
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a timestep; sampled in IDLE only
- weight_valid  in  1  weight_data valid this cycle
- finished  in  1  marks the current valid weight as the last of the timestep
- weight_data  in  NUM_CH*FRACTION_WIDTH  lane i at [i*F +: F], signed
- vmem_in  in  NUM_CH*DATA_WIDTH  initial membrane per lane, signed
- threshold  in  DATA_WIDTH  firing threshold, shared, signed, positive
- ready_mem  out  1  weight accepted when ready_mem & weight_valid
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; spike_out/vmem_out valid
- spike_out  out  NUM_CH  per-lane spike, held until next start
- vmem_out  out  NUM_CH*DATA_WIDTH  per-lane membrane after fire

## Operation
- States: IDLE, LOAD, ACCUM, BLOCK_DONE, FIRE, DONE.
- IDLE: ready_mem=0; start -> LOAD. Nothing else has effect.
- LOAD: vmem[i] <= vmem_in lane i; partial sums and count cleared; spike_out cleared; -> ACCUM.
- ACCUM: ready_mem=1. On accept: partial[i] += sign-extend(weight lane i); count++. If accepted with finished=1 -> BLOCK_DONE with last flag set; else if count==BLOCK_LEN-1 on accept -> BLOCK_DONE. finished without weight_valid is ignored.
- BLOCK_DONE: ready_mem=0; vmem[i] <= sat(vmem[i]+partial[i]); partial and count cleared; last ? FIRE : ACCUM.
- FIRE: if vmem[i] >= threshold: spike[i]=1, vmem[i] <= vmem[i]-threshold; else spike[i]=0. -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- Arithmetic: weight sign-extended to DATA_WIDTH (occupies fraction bits). Partial width DATA_WIDTH+SIZE_CODE, no overflow possible. Block add saturates to [-2^(D-1), 2^(D-1)-1]; fire subtraction cannot overflow (threshold positive).
- Reset: any state -> IDLE; ready_mem, busy, done, spike_out = 0; vmem, vmem_out, partial, count = 0. Reset mid-timestep discards all progress.

## Timing
- LOAD one cycle after start sampled; ready_mem high the cycle after LOAD.
- One weight per cycle max; one bubble cycle (BLOCK_DONE) after every full block.
- Last weight accepted in cycle t: BLOCK_DONE t+1, FIRE t+2, done=1 at t+3; spike_out/vmem_out valid from t+3 until next LOAD.
- Block of exactly BLOCK_LEN with finished on final weight: single BLOCK_DONE, then FIRE.

## Configuration
- LIF_LEAK_EN defined: in FIRE, first vmem[i] <= vmem[i] - (vmem[i] >>> LEAK_SHIFT) (arithmetic shift), then compare/subtract on the leaked value, same cycle. Latency unchanged.
- Undefined: pure PIF, no leak; LEAK_SHIFT unused.

## Structure
- Shared package neuron_pkg: state enum, saturating-add function, width localparams (DATA_WIDTH, partial width).
- Sub-module neuron_lane (partial accumulator, saturating block add, leak, fire), generated NUM_CH times; top holds FSM and block counter.

## Test plan
- I=8,F=8,NUM_CH=1, threshold 0x0100, vmem_in 0x00C0, weights 0x20,0x20 (finished on 2nd) -> done at t+3, spike=1, vmem_out 0x0000.
- vmem_in 0x7F00, 40 weights 0x7F, SIZE_CODE=5 -> saturates, vmem before fire 0x7FFF, spike=1, vmem_out 0x7EFF.
- Negative: vmem_in 0x0000, weights 0x80 x3 -> vmem_out 0xFE80, spike=0.
- SIZE_CODE=2, 9 weights 0x10, vmem_in 0 -> three BLOCK_DONE cycles (ready_mem low after weights 4 and 8), vmem_out 0x0090.
- Reset asserted mid-ACCUM -> next cycle IDLE, all outputs 0; new start with vmem_in 0x0050, no weights besides one 0x00 with finished -> vmem_out 0x0050.
- LIF_LEAK_EN, LEAK_SHIFT=2, vmem_in 0x0080, one weight 0x00 finished -> spike=0, vmem_out 0x0060; same without macro -> 0x0080.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared definitions for the PIF neuron group: FSM state encoding,
// default widths and the saturating add used when a block is folded into vmem.
package neuron_pkg;

  localparam int DEF_INTEGER_WIDTH  = 8;
  localparam int DEF_FRACTION_WIDTH = 8;
  localparam int DEF_SIZE_CODE      = 5;
  localparam int DEF_DATA_WIDTH     = DEF_INTEGER_WIDTH + DEF_FRACTION_WIDTH;
  localparam int DEF_PARTIAL_WIDTH  = DEF_DATA_WIDTH + DEF_SIZE_CODE;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LOAD       = 3'd1;
  localparam state_t ST_ACCUM      = 3'd2;
  localparam state_t ST_BLOCK_DONE = 3'd3;
  localparam state_t ST_FIRE       = 3'd4;
  localparam state_t ST_DONE       = 3'd5;

  // a + b clipped to the signed range of a w-bit word (w <= 62)
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/neuron_lane.sv
// One neuron lane: block partial accumulator, saturating fold into vmem, fire.
// Define LIF_LEAK_EN to apply vmem -= vmem >>> LEAK_SHIFT just before the fire compare.
module neuron_lane
  import neuron_pkg::*;
#(
  parameter int FRACTION_WIDTH = DEF_FRACTION_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int SIZE_CODE      = DEF_SIZE_CODE,
  parameter int LEAK_SHIFT     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic                  accept_i,
  input  logic                  block_i,
  input  logic                  fire_i,
  input  logic [FRACTION_WIDTH-1:0] weight_i,
  input  logic [DATA_WIDTH-1:0] vmem_init_i,
  input  logic [DATA_WIDTH-1:0] threshold_i,
  output logic                  spike_o,
  output logic [DATA_WIDTH-1:0] vmem_o
);

`ifdef LIF_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif

  localparam int PW = DATA_WIDTH + SIZE_CODE;

  logic signed [PW-1:0]         partial_q, partial_d;
  logic signed [DATA_WIDTH-1:0] vmem_q, vmem_d;
  logic signed [DATA_WIDTH-1:0] leaked, thr;
  logic                         spike_q, spike_d;

  assign thr    = signed'(threshold_i);
  assign leaked = LEAK_EN ? vmem_q - (vmem_q >>> LEAK_SHIFT) : vmem_q;

  always_comb begin
    partial_d = partial_q;
    vmem_d    = vmem_q;
    spike_d   = spike_q;
    if (load_i) begin
      vmem_d    = signed'(vmem_init_i);
      partial_d = '0;
      spike_d   = 1'b0;
    end else if (accept_i) begin
      partial_d = partial_q + PW'(signed'(weight_i));
    end else if (block_i) begin
      vmem_d    = DATA_WIDTH'(sat_add(64'(vmem_q), 64'(partial_q), DATA_WIDTH));
      partial_d = '0;
    end else if (fire_i) begin
      // threshold is positive, so leaked - thr stays in range
      if (leaked >= thr) begin
        spike_d = 1'b1;
        vmem_d  = leaked - thr;
      end else begin
        spike_d = 1'b0;
        vmem_d  = leaked;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      partial_q <= '0;
      vmem_q    <= '0;
      spike_q   <= 1'b0;
    end else begin
      partial_q <= partial_d;
      vmem_q    <= vmem_d;
      spike_q   <= spike_d;
    end
  end

  assign spike_o = spike_q;
  assign vmem_o  = vmem_q;

endmodule

// File: rtl/full_neuron_pif_multi.sv
// Multi-lane PIF neuron controller: FSM and block counter driving NUM_CH neuron_lane
// instances. Optional leak is enabled by defining LIF_LEAK_EN (see neuron_lane).
module full_neuron_pif_multi
  import neuron_pkg::*;
#(
  parameter int INTEGER_WIDTH  = DEF_INTEGER_WIDTH,
  parameter int FRACTION_WIDTH = DEF_FRACTION_WIDTH,
  parameter int DATA_WIDTH     = INTEGER_WIDTH + FRACTION_WIDTH,
  parameter int SIZE_CODE      = DEF_SIZE_CODE,
  parameter int NUM_CH         = 4,
  parameter int LEAK_SHIFT     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         weight_valid,
  input  logic                         finished,
  input  logic [NUM_CH*FRACTION_WIDTH-1:0] weight_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0] vmem_in,
  input  logic [DATA_WIDTH-1:0]        threshold,
  output logic                         ready_mem,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_CH-1:0]            spike_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] vmem_out
);

  localparam int BLOCK_LEN = 1 << SIZE_CODE;
  localparam int CW        = (SIZE_CODE > 0) ? SIZE_CODE : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_q, last_d;
  logic            accept;

  assign ready_mem = (state_q == ST_ACCUM);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign accept    = ready_mem & weight_valid;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = '0;
        last_d  = 1'b0;
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        // finished without a valid weight carries no information and is dropped
        if (accept) begin
          count_d = count_q + 1'b1;
          if (finished) begin
            last_d  = 1'b1;
            state_d = ST_BLOCK_DONE;
          end else if (count_q == CW'(BLOCK_LEN - 1)) begin
            state_d = ST_BLOCK_DONE;
          end
        end
      end
      ST_BLOCK_DONE: begin
        count_d = '0;
        state_d = last_q ? ST_FIRE : ST_ACCUM;
      end
      ST_FIRE:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
      neuron_lane #(
        .FRACTION_WIDTH (FRACTION_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .SIZE_CODE      (SIZE_CODE),
        .LEAK_SHIFT     (LEAK_SHIFT)
      ) u_lane (
        .clk         (clk),
        .reset       (reset),
        .load_i      (state_q == ST_LOAD),
        .accept_i    (accept),
        .block_i     (state_q == ST_BLOCK_DONE),
        .fire_i      (state_q == ST_FIRE),
        .weight_i    (weight_data[gi*FRACTION_WIDTH +: FRACTION_WIDTH]),
        .vmem_init_i (vmem_in[gi*DATA_WIDTH +: DATA_WIDTH]),
        .threshold_i (threshold),
        .spike_o     (spike_out[gi]),
        .vmem_o      (vmem_out[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

endmodule

// File: tb/tb_full_neuron_pif_multi.sv
// Scoreboard bench for full_neuron_pif_multi (4 lanes, 4-weight blocks, Q8.8).
module tb_full_neuron_pif_multi;

  localparam int NCH = 4;
  localparam int F   = 8;
  localparam int D   = 16;
  localparam int SC  = 2;
  localparam int BL  = 4;
  localparam int LS  = 2;
  localparam logic [15:0] THR = 16'h0100;

  logic clk = 1'b0;
  logic reset, start, weight_valid, finished;
  logic [NCH*F-1:0] weight_data;
  logic [NCH*D-1:0] vmem_in;
  logic [D-1:0]     threshold;
  logic             ready_mem, busy, done;
  logic [NCH-1:0]   spike_out;
  logic [NCH*D-1:0] vmem_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [NCH-1:0]   spk;
    logic [NCH*D-1:0] vm;
    int               bubbles;
  } exp_t;

  exp_t exp_q[$];
  logic [NCH*F-1:0] wq[$];

  always #5 clk = ~clk;

  full_neuron_pif_multi #(
    .INTEGER_WIDTH (8),
    .FRACTION_WIDTH(F),
    .DATA_WIDTH    (D),
    .SIZE_CODE     (SC),
    .NUM_CH        (NCH),
    .LEAK_SHIFT    (LS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .weight_valid(weight_valid),
    .finished    (finished),
    .weight_data (weight_data),
    .vmem_in     (vmem_in),
    .threshold   (threshold),
    .ready_mem   (ready_mem),
    .busy        (busy),
    .done        (done),
    .spike_out   (spike_out),
    .vmem_out    (vmem_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic fill(input int n, input logic [NCH*F-1:0] w);
    for (int k = 0; k < n; k++) wq.push_back(w);
  endtask

  // Integer reference: blocks of BL weights, saturate per block, optional leak, fire.
  task automatic push_expect(input logic [NCH*D-1:0] vin);
    exp_t e;
    int v, p, c, n;
    logic signed [D-1:0] s16;
    logic signed [F-1:0] s8;
    logic [NCH*F-1:0]    wt;
    logic [31:0]         vb;
    n = wq.size();
    e.spk = '0;
    e.vm = '0;
    e.bubbles = (n > 0) ? (n - 1) / BL : 0;
    for (int l = 0; l < NCH; l++) begin
      s16 = vin[l*D +: D];
      v = s16;
      p = 0;
      c = 0;
      for (int k = 0; k < n; k++) begin
        wt = wq[k];
        s8 = wt[l*F +: F];
        p += s8;
        c++;
        if (c == BL || k == n - 1) begin
          v += p;
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
          p = 0;
          c = 0;
        end
      end
`ifdef LIF_LEAK_EN
      v = v - (v >>> LS);
`endif
      if (v >= int'(THR)) begin
        e.spk[l] = 1'b1;
        v = v - int'(THR);
      end
      vb = v;
      e.vm[l*D +: D] = vb[15:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic run_step(input string name, input logic [NCH*D-1:0] vin, input bit gap);
    exp_t e;
    int i, n, bub, cyc, lat;
    push_expect(vin);
    n = wq.size();
    @(negedge clk);
    start = 1'b1;
    vmem_in = vin;
    @(negedge clk);
    start = 1'b0;
    i = 0; bub = 0; cyc = 0;
    while (i < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      weight_valid = 1'b0;
      finished = 1'b0;
      if (ready_mem) begin
        if (gap && (cyc % 3 == 0)) begin
          finished = 1'b1;
        end else begin
          weight_valid = 1'b1;
          weight_data = wq[i];
          finished = (i == n - 1);
          i++;
        end
      end else if (i > 0) begin
        bub++;
      end
    end
    check({name, ".weights_taken"}, 64'(i), 64'(n));
    @(negedge clk);
    weight_valid = 1'b0;
    finished = 1'b0;
    lat = 1;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".done_latency"}, 64'(lat), 64'd3);
    e = exp_q.pop_front();
    check({name, ".spike"}, 64'(spike_out), 64'(e.spk));
    check({name, ".vmem"}, 64'(vmem_out), 64'(e.vm));
    check({name, ".bubbles"}, 64'(bub), 64'(e.bubbles));
    @(negedge clk);
    check({name, ".done_pulse"}, {62'd0, done, busy}, 64'd0);
    check({name, ".spike_held"}, 64'(spike_out), 64'(e.spk));
    wq.delete();
  endtask

  initial begin
    int w;
    reset = 1'b1; start = 1'b1; weight_valid = 1'b0; finished = 1'b0;
    weight_data = '0; vmem_in = 64'h1111_2222_3333_4444; threshold = THR;
    repeat (3) @(negedge clk);
    check("reset.ctrl", {61'd0, ready_mem, busy, done}, 64'd0);
    check("reset.spike", 64'(spike_out), 64'd0);
    check("reset.vmem", 64'(vmem_out), 64'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("idle.busy", {63'd0, busy}, 64'd0);

    // basic fire, negative lane, leak lane, subtract residue
    fill(2, 32'h7F00_8020);
    run_step("basic", 64'h00FF_0080_0000_00C0, 1'b0);

    // saturation at both ends of the range
    fill(40, 32'h7F7F_7F7F);
    run_step("sat", 64'h7FFF_0000_8000_7F00, 1'b0);

    fill(3, 32'h8080_8080);
    run_step("neg", 64'h8000_0010_0000_0000, 1'b1);

    fill(9, 32'h1010_1010);
    run_step("nine", 64'h0000_0000_0000_0000, 1'b0);

    fill(8, 32'h10F0_2001);
    run_step("exact", 64'h00F0_0100_0050_00FF, 1'b0);

    // reset while accumulating
    @(negedge clk);
    start = 1'b1;
    vmem_in = 64'h1234_1234_1234_1234;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!ready_mem && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("mid.reached_accum", {63'd0, ready_mem}, 64'd1);
    weight_valid = 1'b1;
    weight_data = 32'h0101_0101;
    @(negedge clk);
    @(negedge clk);
    weight_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid.ctrl", {61'd0, ready_mem, busy, done}, 64'd0);
    check("mid.vmem", 64'(vmem_out), 64'd0);
    check("mid.spike", 64'(spike_out), 64'd0);

    fill(1, 32'h0000_0000);
    run_step("after_reset", 64'h0050_0050_0050_0050, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
